// File: rtl/sprite_draw_arbiter.sv
// Arbitrates several sprite-drawing channels onto a single VGA pixel write port.
// One channel owns the port from grant until done, request drop, or watchdog expiry.
module sprite_draw_arbiter #(
    parameter int unsigned          NUM_CH     = 5,
    parameter int unsigned          X_W        = 8,
    parameter int unsigned          Y_W        = 7,
    parameter int unsigned          COLOUR_W   = 12,
    parameter bit                   KEY_EN     = 1'b1,
    parameter logic [COLOUR_W-1:0]  KEY_COLOUR = '0,
    parameter bit                   RR_MODE    = 1'b1,
    parameter int unsigned          TIMEOUT    = 4096
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH-1:0]            pix_valid,
    input  logic [NUM_CH-1:0]            done,
    input  logic [NUM_CH*X_W-1:0]        x_in,
    input  logic [NUM_CH*Y_W-1:0]        y_in,
    input  logic [NUM_CH*COLOUR_W-1:0]   colour_in,
    output logic [NUM_CH-1:0]            grant,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);
    localparam int unsigned WD_W  = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StGrant   = 2'd1;
    localparam logic [1:0] StRelease = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                terr_q, terr_d;

    logic [IDX_W-1:0]    owner_idx;
    logic                own_pv, own_done, own_req;
    logic [X_W-1:0]      own_x;
    logic [Y_W-1:0]      own_y;
    logic [COLOUR_W-1:0] own_colour;

    logic [IDX_W-1:0]    hi_idx, lo_idx, win_idx;
    logic                hi_found, lo_found;
    logic                wd_expire, exit_grant;

    // Owner's slices; grant_q is one-hot so at most one iteration matches.
    always_comb begin
        owner_idx  = '0;
        own_pv     = 1'b0;
        own_done   = 1'b0;
        own_req    = 1'b0;
        own_x      = '0;
        own_y      = '0;
        own_colour = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_q[i]) begin
                owner_idx  = IDX_W'(i);
                own_pv     = pix_valid[i];
                own_done   = done[i];
                own_req    = req[i];
                own_x      = x_in[i*X_W +: X_W];
                own_y      = y_in[i*Y_W +: Y_W];
                own_colour = colour_in[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    // Round-robin: first request above last_owner, else wrap to the lowest request.
    always_comb begin
        hi_idx   = '0;
        hi_found = 1'b0;
        lo_idx   = '0;
        lo_found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!hi_found && req[k] && (k > 32'(last_owner_q))) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(k);
            end
            if (!lo_found && req[k]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(k);
            end
        end
        win_idx = (RR_MODE && hi_found) ? hi_idx : lo_idx;
    end

    assign wd_expire  = (wd_q == WD_LAST);
    assign exit_grant = own_done || !own_req || wd_expire;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        wd_d         = wd_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        terr_d       = terr_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        grant_d[k] = (IDX_W'(k) == win_idx);
                    end
                    wd_d    = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                wd_d = wd_q + 1'b1;
                if (own_pv) begin
                    x_d      = own_x;
                    y_d      = own_y;
                    colour_d = own_colour;
                    plot_d   = !(KEY_EN && (own_colour == KEY_COLOUR));
                end
                if (exit_grant) begin
                    state_d      = StRelease;
                    grant_d      = '0;
                    last_owner_d = owner_idx;
                    if (wd_expire) begin
                        terr_d = 1'b1;
                    end
                end
            end
            StRelease: begin
                state_d = StIdle;
                grant_d = '0;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_owner_q <= IDX_W'(NUM_CH - 1);
            wd_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            wd_q         <= wd_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            terr_q       <= terr_d;
        end
    end

    assign grant       = grant_q;
    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign plot        = plot_q;
    assign busy        = (state_q == StGrant) || (state_q == StRelease);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Self-checking bench for sprite_draw_arbiter: round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_sprite_draw_arbiter;

    localparam int unsigned NUM_CH = 5;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [NUM_CH-1:0]      req, pix_valid, done;
    logic [NUM_CH*8-1:0]    x_in;
    logic [NUM_CH*7-1:0]    y_in;
    logic [NUM_CH*12-1:0]   colour_in;

    logic [NUM_CH-1:0] grant, grant_fp;
    logic [7:0]        x, x_fp;
    logic [6:0]        y, y_fp;
    logic [11:0]       colour, colour_fp;
    logic              plot, plot_fp, busy, busy_fp, terr, terr_fp;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [11:0] col;
        logic        plot;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          ch;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [11:0] col;
        logic        plot;
    } vec_t;
    vec_t vecs[6];

    sprite_draw_arbiter #(
        .NUM_CH(5), .X_W(8), .Y_W(7), .COLOUR_W(12), .KEY_EN(1'b1),
        .KEY_COLOUR(12'h000), .RR_MODE(1'b1), .TIMEOUT(8)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req), .pix_valid(pix_valid), .done(done),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant), .x(x), .y(y),
        .colour(colour), .plot(plot), .busy(busy), .timeout_err(terr)
    );

    sprite_draw_arbiter #(
        .NUM_CH(5), .X_W(8), .Y_W(7), .COLOUR_W(12), .KEY_EN(1'b1),
        .KEY_COLOUR(12'h000), .RR_MODE(1'b0), .TIMEOUT(8)
    ) dut_fp (
        .clk(clk), .resetn(resetn), .req(req), .pix_valid(pix_valid), .done(done),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant_fp), .x(x_fp),
        .y(y_fp), .colour(colour_fp), .plot(plot_fp), .busy(busy_fp), .timeout_err(terr_fp)
    );

    always #5 clk = ~clk;

    logic fp_watch = 1'b0;
    logic fp_ch4_seen = 1'b0;
    always @(negedge clk) begin
        if (fp_watch && grant_fp[4]) fp_ch4_seen <= 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [7:0] xv, input logic [6:0] yv,
                          input logic [11:0] cv);
        x_in[ch*8 +: 8]       = xv;
        y_in[ch*7 +: 7]       = yv;
        colour_in[ch*12 +: 12] = cv;
    endtask

    task automatic drive_pix(input int ch, input logic [7:0] xv, input logic [6:0] yv,
                             input logic [11:0] cv, input logic pl);
        exp_t e;
        set_ch(ch, xv, yv, cv);
        pix_valid[ch] = 1'b1;
        e.x = xv; e.y = yv; e.col = cv; e.plot = pl;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got 0 want 1", name);
        end else begin
            e = sb.pop_front();
            check({name, "_x"}, x, e.x);
            check({name, "_y"}, y, e.y);
            check({name, "_colour"}, colour, e.col);
            check({name, "_plot"}, plot, e.plot);
        end
    endtask

    task automatic go_idle();
        req = '0;
        pix_valid = '0;
        done = '0;
        step();
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

    initial begin
        int plots;
        int n;
        logic [NUM_CH-1:0] oh;
        int other;

        vecs[0] = '{1, 8'd10,  7'd20,  12'h000, 1'b0};
        vecs[1] = '{1, 8'd11,  7'd21,  12'hF00, 1'b1};
        vecs[2] = '{3, 8'd159, 7'd119, 12'h0F0, 1'b1};
        vecs[3] = '{0, 8'd0,   7'd0,   12'h001, 1'b1};
        vecs[4] = '{4, 8'd255, 7'd127, 12'hFFF, 1'b1};
        vecs[5] = '{2, 8'd7,   7'd3,   12'h000, 1'b0};

        resetn = 1'b0; req = '0; pix_valid = '0; done = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        step();
        step();
        check("rst_grant", grant, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", terr, 0);
        check("rst_xyc", {x, y, colour}, 0);
        resetn = 1'b1;
        step();

        // Round-robin: ch0 draws 3 pixels, then ch2 gets the port.
        req = 5'b00101;
        step();
        check("rr_first_grant", grant, 5'b00001);
        check("rr_busy", busy, 1);
        plots = 0;
        for (int p = 0; p < 3; p++) begin
            drive_pix(0, 8'(20 + p), 7'(30 + p), 12'(12'h100 + p), 1'b1);
            set_ch(2, 8'hEE, 7'h55, 12'hABC);
            pix_valid[2] = 1'b1;
            done[2] = (p == 0);
            step();
            pop_check("rr_pix");
            plots += int'(plot);
            check("rr_hold_grant", grant, 5'b00001);
        end
        pix_valid = '0;
        done = 5'b00001;
        step();
        plots += int'(plot);
        check("rr_release_grant", grant, 0);
        check("rr_release_busy", busy, 1);
        done = '0;
        step();
        plots += int'(plot);
        check("rr_idle_grant", grant, 0);
        step();
        check("rr_second_grant", grant, 5'b00100);
        check("rr_plot_count", plots, 3);
        go_idle();

        // Table vectors: single-owner pixel forwarding, keying, non-owner ignore.
        foreach (vecs[i]) begin
            oh = '0;
            oh[vecs[i].ch] = 1'b1;
            req = oh;
            step();
            check("vec_grant", grant, oh);
            drive_pix(vecs[i].ch, vecs[i].x, vecs[i].y, vecs[i].col, vecs[i].plot);
            other = (vecs[i].ch + 1) % NUM_CH;
            set_ch(other, 8'h5A, 7'h2B, 12'h777);
            pix_valid[other] = 1'b1;
            step();
            pop_check("vec_pix");
            go_idle();
            check("vec_plot_clear", plot, 0);
        end

        // Done and last pixel on the same cycle.
        req = 5'b00100;
        step();
        check("done_grant", grant, 5'b00100);
        drive_pix(2, 8'd159, 7'd119, 12'h0AB, 1'b1);
        done[2] = 1'b1;
        step();
        pop_check("done_pix");
        check("done_grant_drop", grant, 0);
        go_idle();

        // Watchdog with TIMEOUT=8.
        req = 5'b01000;
        step();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (grant != 5'b01000) break;
            n++;
            step();
        end
        check("wd_grant_cycles", n, 8);
        check("wd_terr", terr, 1);
        check("wd_release_grant", grant, 0);
        check("wd_release_busy", busy, 1);
        step();
        check("wd_idle_grant", grant, 0);
        step();
        check("wd_regrant", grant, 5'b01000);
        check("wd_terr_sticky", terr, 1);
        go_idle();

        // Reset in the middle of a grant.
        req = 5'b00001;
        step();
        check("mid_grant", grant, 5'b00001);
        set_ch(0, 8'd50, 7'd60, 12'h123);
        pix_valid[0] = 1'b1;
        resetn = 1'b0;
        step();
        check("mid_rst_grant", grant, 0);
        check("mid_rst_plot", plot, 0);
        check("mid_rst_x", x, 0);
        check("mid_rst_terr", terr, 0);
        check("mid_rst_busy", busy, 0);
        resetn = 1'b1;
        pix_valid = '0;
        step();
        check("mid_regrant", grant, 5'b00001);
        go_idle();

        // Fixed priority instance: ch3 always beats ch4.
        fp_watch = 1'b1;
        req = 5'b11000;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (grant_fp == '0 && n < 6);
            check("fp_grant", grant_fp, 5'b01000);
            set_ch(3, 8'(r + 1), 7'(r + 2), 12'h0C0);
            pix_valid = 5'b01000;
            step();
            check("fp_plot", plot_fp, 1);
            check("fp_x", x_fp, r + 1);
            pix_valid = '0;
            done = 5'b01000;
            step();
            check("fp_release", grant_fp, 0);
            done = '0;
        end
        step();
        fp_watch = 1'b0;
        check("fp_ch4_never", fp_ch4_seen, 0);
        go_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_draw_arbiter.md
SPRITE_DRAW_ARBITER -- requirements
Module: sprite_draw_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_CH, 5, number of sprite channels (2..16).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 12, colour width.
- KEY_EN, 1, enables transparent colour keying.
- KEY_COLOUR, 12'h000, transparent colour value.
- RR_MODE, 1: round-robin; 0: fixed priority, lowest index wins.
- TIMEOUT, 4096, max cycles one channel may hold the grant (≥2).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all logic on rising edge.
- resetn, in, 1, synchronous active-low reset.
- req, in, NUM_CH, per-channel draw request, level.
- pix_valid, in, NUM_CH, channel presents a pixel this cycle.
- done, in, NUM_CH, channel's sprite complete, 1-cycle pulse.
- x_in, in, NUM_CH*X_W, packed x; channel i at [i*X_W +: X_W].
- y_in, in, NUM_CH*Y_W, packed y, same packing.
- colour_in, in, NUM_CH*COLOUR_W, packed colour, same packing.
- grant, out, NUM_CH, one-hot owner, registered.
- x, out, X_W, registered pixel x to VGA adapter.
- y, out, Y_W, registered pixel y.
- colour, out, COLOUR_W, registered pixel colour.
- plot, out, 1, write strobe to VGA adapter.
- busy, out, 1, high while in GRANT or RELEASE.
- timeout_err, out, 1, sticky, set on watchdog expiry.

Function
REQ-003 States: IDLE, GRANT, RELEASE; state and grant encoding is registered.
REQ-004 IDLE, req==0: stay; grant=0.
REQ-005 IDLE, req!=0: select winner, load grant one-hot, go to GRANT on the next edge. Grant is first visible one cycle after req.
REQ-006 Winner, RR_MODE=1: first set req bit searching upward from (last_owner+1) mod NUM_CH with wrap. last_owner resets to NUM_CH-1, so channel 0 has first priority after reset.
REQ-007 Winner, RR_MODE=0: lowest-index set req bit. last_owner is still tracked but unused.
REQ-008 GRANT: a pixel is forwarded only from the owner. On a cycle with pix_valid[owner]=1, the next edge registers x/y/colour from the owner's slice and sets plot=1. Otherwise plot=0 next cycle and x/y/colour hold.
REQ-009 Keying: with KEY_EN=1 and owner colour==KEY_COLOUR, x/y/colour still update but plot=0.
REQ-010 pix_valid and done from non-owner channels are ignored entirely.
REQ-011 GRANT exits to RELEASE when done[owner]=1, req[owner]=0, or the watchdog expires. The owner's pixel on that same cycle is still forwarded per REQ-008.
REQ-012 On the GRANT→RELEASE edge: grant becomes 0 and last_owner is loaded with the owner index.
REQ-013 RELEASE lasts exactly one cycle with grant=0, then returns to IDLE. Minimum gap between two grants is therefore 2 cycles.
REQ-014 Watchdog counter: cleared on entry to GRANT, increments each GRANT cycle. Expiry is when it reaches TIMEOUT-1 while still in GRANT. Expiry sets timeout_err=1, which holds until reset. Counter width is clog2(TIMEOUT)+1 and never wraps.
REQ-015 busy=1 exactly when state is GRANT or RELEASE.
REQ-016 grant is never multi-hot. plot is never 1 on a cycle whose preceding cycle had grant=0.

Reset
REQ-017 When resetn=0 at a rising edge, the next state is:
- state IDLE; grant=0; plot=0; busy=0; timeout_err=0.
- x=0; y=0; colour=0; watchdog=0; last_owner=NUM_CH-1.
REQ-018 Reset mid-GRANT aborts the draw. No pixel from the reset cycle is forwarded.

Verification
REQ-019 NUM_CH=5, RR_MODE=1: req=5'b00101 held; ch0 done after 3 pixels → grant 00001, then RELEASE, then grant 00100. Exactly 3 plot pulses precede the ch2 grant.
REQ-020 RR_MODE=0: req=5'b11000 held, each owner done after 1 pixel → grant is always 01000; ch4 is never granted.
REQ-021 Owner ch1, pix_valid[1]=1, colour=12'h000, KEY_EN=1 → x/y update, plot=0. Same stimulus with colour=12'hF00 → plot=1, colour=12'hF00.
REQ-022 TIMEOUT=8, ch3 holds req with no done → grant drops after 8 GRANT cycles and timeout_err=1. After a further idle cycle, ch3 is re-granted while timeout_err stays 1.
REQ-023 ch0 in GRANT with pix_valid; resetn=0 for 1 cycle → next cycle grant=0, plot=0, x=0, timeout_err=0. Re-request is then granted 1 cycle after release of reset.
REQ-024 Owner ch2 asserts done and pix_valid in the same cycle (x=8'd159, y=7'd119) → plot=1 with x=159, y=119 on the same edge that grant goes to 0.
